// File: rtl/usb_fifo_test_seq.sv
// Pattern traffic generator/checker driving the USBCtrl slave-FIFO write and read burst handshakes.
// One Start runs a write burst, a checked read burst, or a write-then-read loopback.
module usb_fifo_test_seq #(
   parameter int unsigned     DW        = 16,
   parameter int unsigned     CW        = 10,
   parameter int unsigned     TO_W      = 16,
   parameter logic [DW-1:0]   LFSR_TAPS = 16'hB400
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            Start,
   input  logic [1:0]      Mode,
   input  logic [1:0]      PatSel,
   input  logic [DW-1:0]   Seed,
   input  logic [CW-1:0]   Count,
   input  logic [TO_W-1:0] TimeoutLim,
   output logic            WEnable,
   output logic [CW-1:0]   WCnt,
   output logic [DW-1:0]   Send,
   input  logic            WTake,
   input  logic            WDone,
   output logic            REnable,
   output logic [CW-1:0]   RCnt,
   input  logic [DW-1:0]   Receive,
   input  logic            RReady,
   output logic [DW-1:0]   RcvOut,
   output logic            Busy,
   output logic            Done,
   output logic [CW-1:0]   ErrCnt,
   output logic [CW-1:0]   FirstErrIdx,
   output logic            Timeout,
   output logic            ShortW
);

   typedef enum logic [2:0] {IDLE, W_RUN, W_WAIT, R_RUN, FIN} state_t;

   state_t          state_q, state_d;
   logic            loop_q, loop_d;
   logic [1:0]      pat_q, pat_d;
   logic [DW-1:0]   seed_q, seed_d;
   logic [CW-1:0]   count_q, count_d;
   logic [TO_W-1:0] tolim_q, tolim_d;
   logic [DW-1:0]   gen_q, gen_d;
   logic [CW-1:0]   taken_q, taken_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [TO_W-1:0] idle_q, idle_d;
   logic            wen_q, wen_d;
   logic            ren_q, ren_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic [CW-1:0]   rcnt_q, rcnt_d;
   logic [DW-1:0]   rcv_q, rcv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [CW-1:0]   err_q, err_d;
   logic [CW-1:0]   ferr_q, ferr_d;
   logic            tmo_q, tmo_d;
   logic            shortw_q, shortw_d;

   logic            evt;
   logic            tmo_hit;
   logic            go_fin;
   logic            go_read;
   logic [TO_W-1:0] idle_inc;
   logic [CW-1:0]   taken_nx;
   logic [CW-1:0]   idx_nx;

   function automatic logic [DW-1:0] gen_step(input logic [DW-1:0] g, input logic [1:0] p);
      logic [DW-1:0] r;
      case (p)
         2'd0:    r = g + DW'(1);
         2'd1:    r = g;
         2'd2:    r = (g >> 1) ^ (g[0] ? LFSR_TAPS : '0);
         default: r = {g[DW-2:0], g[DW-1]};
      endcase
      return r;
   endfunction

   // LFSR and walking-one would lock up on an all-zero seed
   function automatic logic [DW-1:0] fix_seed(input logic [DW-1:0] s, input logic [1:0] p);
      return (p[1] && (s == '0)) ? DW'(1) : s;
   endfunction

   always_comb begin
      state_d  = state_q;
      loop_d   = loop_q;
      pat_d    = pat_q;
      seed_d   = seed_q;
      count_d  = count_q;
      tolim_d  = tolim_q;
      gen_d    = gen_q;
      taken_d  = taken_q;
      idx_d    = idx_q;
      idle_d   = '0;
      wen_d    = wen_q;
      ren_d    = ren_q;
      wcnt_d   = wcnt_q;
      rcnt_d   = rcnt_q;
      rcv_d    = rcv_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      ferr_d   = ferr_q;
      tmo_d    = tmo_q;
      shortw_d = shortw_q;
      go_fin   = 1'b0;
      go_read  = 1'b0;

      evt      = WTake | RReady | WDone;
      idle_inc = idle_q + TO_W'(1);
      tmo_hit  = (tolim_q != '0) && !evt && (idle_inc == tolim_q);
      taken_nx = taken_q + CW'(WTake);
      idx_nx   = idx_q + CW'(1);

      case (state_q)
         IDLE, FIN: begin
            if (state_q == FIN) state_d = IDLE;
            if (Start) begin
               loop_d   = (Mode == 2'd2);
               pat_d    = PatSel;
               seed_d   = fix_seed(Seed, PatSel);
               gen_d    = fix_seed(Seed, PatSel);
               count_d  = Count;
               tolim_d  = TimeoutLim;
               err_d    = '0;
               ferr_d   = '0;
               tmo_d    = 1'b0;
               shortw_d = 1'b0;
               taken_d  = '0;
               idx_d    = '0;
               busy_d   = 1'b1;
               if (Count == '0) begin
                  go_fin = 1'b1;
               end else if (Mode == 2'd1) begin
                  state_d = R_RUN;
                  ren_d   = 1'b1;
                  rcnt_d  = Count;
               end else begin
                  state_d = W_RUN;
                  wen_d   = 1'b1;
                  wcnt_d  = Count;
               end
            end
         end
         W_RUN: begin
            idle_d = evt ? '0 : idle_inc;
            if (WTake) begin
               gen_d   = gen_step(gen_q, pat_q);
               taken_d = taken_nx;
            end
            // A take in the same cycle as WDone still counts toward completion
            if (WDone) begin
               shortw_d = shortw_q | (taken_nx != count_q);
               go_read  = loop_q;
               go_fin   = !loop_q;
            end else if (taken_nx == count_q) begin
               state_d = W_WAIT;
               idle_d  = '0;
            end else if (tmo_hit) begin
               tmo_d  = 1'b1;
               go_fin = 1'b1;
            end
         end
         W_WAIT: begin
            idle_d = evt ? '0 : idle_inc;
            if (WDone) begin
               go_read = loop_q;
               go_fin  = !loop_q;
            end else if (tmo_hit) begin
               tmo_d  = 1'b1;
               go_fin = 1'b1;
            end
         end
         R_RUN: begin
            idle_d = evt ? '0 : idle_inc;
            if (RReady) begin
               rcv_d = Receive;
               gen_d = gen_step(gen_q, pat_q);
               idx_d = idx_nx;
               if (Receive != gen_q) begin
                  if (err_q != '1) err_d = err_q + CW'(1);
                  if (err_q == '0) ferr_d = idx_q;
               end
               if (idx_nx == count_q) go_fin = 1'b1;
            end else if (tmo_hit) begin
               tmo_d  = 1'b1;
               go_fin = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (go_read) begin
         state_d = R_RUN;
         wen_d   = 1'b0;
         ren_d   = 1'b1;
         rcnt_d  = count_q;
         gen_d   = seed_q;
         idx_d   = '0;
         idle_d  = '0;
      end
      if (go_fin) begin
         state_d = FIN;
         wen_d   = 1'b0;
         ren_d   = 1'b0;
         wcnt_d  = '0;
         rcnt_d  = '0;
         busy_d  = 1'b0;
         done_d  = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         loop_q   <= 1'b0;
         pat_q    <= '0;
         seed_q   <= '0;
         count_q  <= '0;
         tolim_q  <= '0;
         gen_q    <= '0;
         taken_q  <= '0;
         idx_q    <= '0;
         idle_q   <= '0;
         wen_q    <= 1'b0;
         ren_q    <= 1'b0;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
         rcv_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= '0;
         ferr_q   <= '0;
         tmo_q    <= 1'b0;
         shortw_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         loop_q   <= loop_d;
         pat_q    <= pat_d;
         seed_q   <= seed_d;
         count_q  <= count_d;
         tolim_q  <= tolim_d;
         gen_q    <= gen_d;
         taken_q  <= taken_d;
         idx_q    <= idx_d;
         idle_q   <= idle_d;
         wen_q    <= wen_d;
         ren_q    <= ren_d;
         wcnt_q   <= wcnt_d;
         rcnt_q   <= rcnt_d;
         rcv_q    <= rcv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ferr_q   <= ferr_d;
         tmo_q    <= tmo_d;
         shortw_q <= shortw_d;
      end
   end

   assign WEnable     = wen_q;
   assign WCnt        = wcnt_q;
   assign Send        = gen_q;
   assign REnable     = ren_q;
   assign RCnt        = rcnt_q;
   assign RcvOut      = rcv_q;
   assign Busy        = busy_q;
   assign Done        = done_q;
   assign ErrCnt      = err_q;
   assign FirstErrIdx = ferr_q;
   assign Timeout     = tmo_q;
   assign ShortW      = shortw_q;

endmodule

// File: tb/tb_usb_fifo_test_seq.sv
// Bench acting as USBCtrl around usb_fifo_test_seq; expected words come from a closed-form pattern model.
module tb_usb_fifo_test_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  Mode = '0;
   logic [1:0]  PatSel = '0;
   logic [15:0] Seed = '0;
   logic [9:0]  Count = '0;
   logic [15:0] TimeoutLim = '0;
   logic        WTake = 1'b0;
   logic        WDone = 1'b0;
   logic        RReady = 1'b0;
   logic [15:0] Receive = '0;
   logic        WEnable, REnable, Busy, Done, Timeout, ShortW;
   logic [9:0]  WCnt, RCnt, ErrCnt, FirstErrIdx;
   logic [15:0] Send, RcvOut;

   int checks = 0;
   int failures = 0;

   usb_fifo_test_seq dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Mode(Mode), .PatSel(PatSel), .Seed(Seed),
      .Count(Count), .TimeoutLim(TimeoutLim), .WEnable(WEnable), .WCnt(WCnt), .Send(Send),
      .WTake(WTake), .WDone(WDone), .REnable(REnable), .RCnt(RCnt), .Receive(Receive),
      .RReady(RReady), .RcvOut(RcvOut), .Busy(Busy), .Done(Done), .ErrCnt(ErrCnt),
      .FirstErrIdx(FirstErrIdx), .Timeout(Timeout), .ShortW(ShortW)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Word number i of a burst, computed directly from seed and pattern kind
   function automatic logic [15:0] exp_word(input logic [15:0] seed, input logic [1:0] pat, input int i);
      logic [15:0] s;
      logic [31:0] d;
      s = seed;
      if (pat >= 2'd2 && s == 16'd0) s = 16'd1;
      case (pat)
         2'd0: return s + 16'(i);
         2'd1: return s;
         2'd2: begin
            for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
            return s;
         end
         default: begin
            d = {s, s} << (i % 16);
            return d[31:16];
         end
      endcase
   endfunction

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic start_seq(input logic [1:0] m, input logic [1:0] p, input logic [15:0] s,
                            input logic [9:0] c, input logic [15:0] tl);
      Mode = m; PatSel = p; Seed = s; Count = c; TimeoutLim = tl;
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b0;
      #3;
      checks++; if ({WEnable, REnable, Busy, Done, Timeout, ShortW} !== 6'b0) begin failures++; $display("FAIL reset_flags: got %b want 000000", {WEnable, REnable, Busy, Done, Timeout, ShortW}); end
      checks++; if ({WCnt, RCnt, ErrCnt, FirstErrIdx} !== 40'b0) begin failures++; $display("FAIL reset_counts: got %h want 0", {WCnt, RCnt, ErrCnt, FirstErrIdx}); end
      checks++; if ({Send, RcvOut} !== 32'b0) begin failures++; $display("FAIL reset_data: got %h want 0", {Send, RcvOut}); end
      tick();
      RST = 1'b1;
      tick();
   endtask

   task automatic test_incr_write;
      int wen_cycles = 0;
      int bad = 0;
      start_seq(2'd0, 2'd0, 16'h12FA, 10'd10, 16'd0);
      checks++; if (Busy !== 1'b1 || WCnt !== 10'd10) begin failures++; $display("FAIL incr_start: busy=%b wcnt=%0d want 1/10", Busy, WCnt); end
      WTake = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (Send !== 16'h12FA + 16'(i)) bad++;
         if (WEnable === 1'b1) wen_cycles++;
         tick();
      end
      WTake = 1'b0;
      checks++; if (bad != 0) begin failures++; $display("FAIL incr_send: %0d wrong words want 0", bad); end
      if (WEnable === 1'b1) wen_cycles++;
      tick();
      WDone = 1'b1;
      if (WEnable === 1'b1) wen_cycles++;
      tick();
      WDone = 1'b0;
      checks++; if (wen_cycles != 12 || WEnable !== 1'b0) begin failures++; $display("FAIL incr_wen: cycles=%0d wen=%b want 12/0", wen_cycles, WEnable); end
      checks++; if (Done !== 1'b1 || ShortW !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL incr_done: done=%b shortw=%b busy=%b want 1/0/0", Done, ShortW, Busy); end
      tick();
      checks++; if (Done !== 1'b0) begin failures++; $display("FAIL incr_pulse: done=%b want 0", Done); end
   endtask

   task automatic test_loopback;
      int bad = 0;
      start_seq(2'd2, 2'd2, 16'hACE1, 10'd5, 16'd0);
      WTake = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (Send !== exp_word(16'hACE1, 2'd2, i)) bad++;
         tick();
      end
      WTake = 1'b0;
      WDone = 1'b1;
      tick();
      WDone = 1'b0;
      checks++; if (bad != 0) begin failures++; $display("FAIL loop_send: %0d wrong words want 0", bad); end
      checks++; if (REnable !== 1'b1 || RCnt !== 10'd5 || WEnable !== 1'b0) begin failures++; $display("FAIL loop_read_start: ren=%b rcnt=%0d wen=%b want 1/5/0", REnable, RCnt, WEnable); end
      RReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         Receive = exp_word(16'hACE1, 2'd2, i);
         tick();
      end
      RReady = 1'b0;
      checks++; if (ErrCnt !== 10'd0 || Done !== 1'b1) begin failures++; $display("FAIL loop_result: errcnt=%0d done=%b want 0/1", ErrCnt, Done); end
      checks++; if (RcvOut !== exp_word(16'hACE1, 2'd2, 4)) begin failures++; $display("FAIL loop_rcvout: got %h want %h", RcvOut, exp_word(16'hACE1, 2'd2, 4)); end
      tick();
   endtask

   task automatic test_read_mismatch;
      logic [15:0] data [4] = '{16'd0, 16'd1, 16'd7, 16'd3};
      start_seq(2'd1, 2'd0, 16'd0, 10'd4, 16'd0);
      checks++; if (REnable !== 1'b1 || RCnt !== 10'd4) begin failures++; $display("FAIL rd_start: ren=%b rcnt=%0d want 1/4", REnable, RCnt); end
      RReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Receive = data[i];
         tick();
      end
      RReady = 1'b0;
      checks++; if (ErrCnt !== 10'd1 || FirstErrIdx !== 10'd2) begin failures++; $display("FAIL rd_err: errcnt=%0d first=%0d want 1/2", ErrCnt, FirstErrIdx); end
      checks++; if (RcvOut !== 16'd3 || Done !== 1'b1 || REnable !== 1'b0) begin failures++; $display("FAIL rd_end: rcv=%h done=%b ren=%b want 3/1/0", RcvOut, Done, REnable); end
      tick();
   endtask

   task automatic test_short_write;
      start_seq(2'd0, 2'd0, 16'h0040, 10'd8, 16'd0);
      WTake = 1'b1;
      repeat (3) tick();
      WTake = 1'b0;
      WDone = 1'b1;
      tick();
      WDone = 1'b0;
      checks++; if (ShortW !== 1'b1 || WEnable !== 1'b0) begin failures++; $display("FAIL short_flag: shortw=%b wen=%b want 1/0", ShortW, WEnable); end
      checks++; if (Done !== 1'b1 || WCnt !== 10'd0) begin failures++; $display("FAIL short_done: done=%b wcnt=%0d want 1/0", Done, WCnt); end
      tick();
   endtask

   task automatic test_timeout;
      int early = 0;
      start_seq(2'd1, 2'd0, 16'd0, 10'd4, 16'd20);
      RReady = 1'b1;
      Receive = 16'd0;
      tick();
      Receive = 16'd1;
      tick();
      RReady = 1'b0;
      for (int i = 1; i < 20; i++) begin
         tick();
         if (Timeout !== 1'b0 || Done !== 1'b0) early++;
      end
      checks++; if (early != 0) begin failures++; $display("FAIL tmo_early: %0d early cycles want 0", early); end
      tick();
      checks++; if (Timeout !== 1'b1 || REnable !== 1'b0) begin failures++; $display("FAIL tmo_flag: tmo=%b ren=%b want 1/0", Timeout, REnable); end
      checks++; if (Done !== 1'b1 || ErrCnt !== 10'd0) begin failures++; $display("FAIL tmo_done: done=%b errcnt=%0d want 1/0", Done, ErrCnt); end
      tick();
   endtask

   task automatic test_count_zero;
      start_seq(2'd0, 2'd0, 16'd5, 10'd0, 16'd0);
      checks++; if (Done !== 1'b1 || WEnable !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL cnt0: done=%b wen=%b busy=%b want 1/0/0", Done, WEnable, Busy); end
      tick();
   endtask

   task automatic test_busy_and_reset;
      int bad = 0;
      start_seq(2'd0, 2'd0, 16'd100, 10'd6, 16'd0);
      WTake = 1'b1;
      repeat (2) tick();
      WTake = 1'b0;
      Mode = 2'd1; Count = 10'd3; Seed = 16'd7;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      checks++; if (WCnt !== 10'd6 || WEnable !== 1'b1 || REnable !== 1'b0) begin failures++; $display("FAIL busy_ignore: wcnt=%0d wen=%b ren=%b want 6/1/0", WCnt, WEnable, REnable); end
      checks++; if (Send !== 16'd102) begin failures++; $display("FAIL busy_send: got %0d want 102", Send); end
      #2 RST = 1'b0;
      #1;
      checks++; if ({WEnable, REnable, Busy, Done, WCnt, Send} !== 30'b0) begin failures++; $display("FAIL midreset: got %h want 0", {WEnable, REnable, Busy, Done, WCnt, Send}); end
      tick();
      RST = 1'b1;
      repeat (5) begin
         tick();
         if (Done !== 1'b0 || Busy !== 1'b0 || WEnable !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL postreset: %0d active cycles want 0", bad); end
   endtask

   task automatic test_random;
      for (int n = 0; n < 16; n++) begin
         logic [1:0]  m, p;
         logic [15:0] s, d, last;
         int          cnt, taken, errs, first;
         m = 2'($urandom_range(0, 3));
         p = 2'($urandom_range(0, 3));
         s = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         cnt = $urandom_range(1, 12);
         start_seq(m, p, s, 10'(cnt), 16'd0);
         if (m != 2'd1) begin
            taken = 0;
            while (taken < cnt) begin
               if ($urandom_range(0, 2) != 0) begin
                  checks++; if (Send !== exp_word(s, p, taken)) begin failures++; $display("FAIL rnd_send: txn %0d word %0d got %h want %h", n, taken, Send, exp_word(s, p, taken)); end
                  WTake = 1'b1;
                  taken++;
               end
               tick();
               WTake = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick();
            WDone = 1'b1;
            tick();
            WDone = 1'b0;
            if (m == 2'd2) begin
               checks++; if (REnable !== 1'b1 || WEnable !== 1'b0) begin failures++; $display("FAIL rnd_loop: txn %0d ren=%b wen=%b want 1/0", n, REnable, WEnable); end
            end else begin
               checks++; if (Done !== 1'b1 || ShortW !== 1'b0 || WEnable !== 1'b0) begin failures++; $display("FAIL rnd_wdone: txn %0d done=%b shortw=%b wen=%b want 1/0/0", n, Done, ShortW, WEnable); end
            end
         end
         if (m == 2'd1 || m == 2'd2) begin
            errs = 0; first = 0; last = '0;
            for (int j = 0; j < cnt; j++) begin
               repeat ($urandom_range(0, 2)) tick();
               d = exp_word(s, p, j);
               if ($urandom_range(0, 3) == 0) d = d ^ 16'($urandom_range(1, 65535));
               if (d != exp_word(s, p, j)) begin
                  if (errs == 0) first = j;
                  errs++;
               end
               last = d;
               Receive = d;
               RReady = 1'b1;
               tick();
               RReady = 1'b0;
            end
            checks++; if (Done !== 1'b1 || ErrCnt !== 10'(errs) || RcvOut !== last) begin failures++; $display("FAIL rnd_read: txn %0d done=%b err=%0d rcv=%h want 1/%0d/%h", n, Done, ErrCnt, RcvOut, errs, last); end
            if (errs != 0) begin
               checks++; if (FirstErrIdx !== 10'(first)) begin failures++; $display("FAIL rnd_first: txn %0d got %0d want %0d", n, FirstErrIdx, first); end
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_incr_write();
      test_loopback();
      test_read_mismatch();
      test_short_write();
      test_timeout();
      test_count_zero();
      test_busy_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/usb_fifo_test_seq.md
Name: usb_fifo_test_seq

Overview:
Parametrised traffic generator and checker for the USB2.0 Slave FIFO controller (USBCtrl). On a Start pulse it issues one write burst of pattern words, one read burst checked against the expected pattern, or a write-then-read loopback. It reports error count, first-error index, timeout and completion. It sits between board test logic and USBCtrl's WEnable/WDone/REnable/RReady interface, and is the parametrised successor to the fixed single-word USBTest harness.

Parameters:
DW, 16, data word width (Send/Receive/RcvOut)
CW, 10, burst count width (WCnt/RCnt, max 2^CW-1 words)
TO_W, 16, width of the no-progress timeout counter
LFSR_TAPS, 16'hB400, Galois LFSR tap mask (DW bits)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
Start  in  1  one-cycle start pulse; ignored while Busy
Mode  in  2  0=write only, 1=read only, 2=write then read (loopback), 3=reserved (treated as 0)
PatSel  in  2  0=increment, 1=constant, 2=LFSR, 3=walking-one
Seed  in  DW  pattern seed
Count  in  CW  words per burst
TimeoutLim  in  TO_W  idle cycles allowed between words
WEnable  out  1  write burst request to USBCtrl
WCnt  out  CW  words to write
Send  out  DW  current write word
WTake  in  1  USBCtrl consumed Send this cycle
WDone  in  1  USBCtrl finished write burst
REnable  out  1  read burst request to USBCtrl
RCnt  out  CW  words to read
Receive  in  DW  read data
RReady  in  1  Receive valid this cycle
RcvOut  out  DW  last received word
Busy  out  1  sequence in progress
Done  out  1  one-cycle completion pulse
ErrCnt  out  CW  mismatch count, saturating at all-ones
FirstErrIdx  out  CW  index of first mismatch (valid when ErrCnt!=0)
Timeout  out  1  sticky: a phase aborted on timeout
ShortW  out  1  sticky: WDone arrived before Count words taken

Behaviour:
- Reset: every output 0, state IDLE, generator = 0.
- States: IDLE, W_RUN, W_WAIT, R_RUN, FIN.
- IDLE: on Start (Busy=0), latch Mode, PatSel, Seed, Count and TimeoutLim; clear ErrCnt, FirstErrIdx, Timeout and ShortW; load generator = Seed; Busy=1. Next state is W_RUN for Mode 0/2/3, R_RUN for Mode 1. Count=0 goes straight to FIN.
- W_RUN: WEnable=1, WCnt=Count, Send=generator.
  - On WTake: advance generator; Send shows the next word on the following cycle; increment taken counter.
  - After Count takes, go to W_WAIT.
  - WDone seen in W_RUN before Count takes: set ShortW, drop WEnable, go to the next phase.
  - WTake together with WDone: count the word first, then evaluate short.
  - WTake beyond Count is ignored.
- W_WAIT: hold WEnable until WDone, then WEnable=0. Mode 2 reloads generator=Seed and goes to R_RUN; otherwise go to FIN.
- R_RUN: REnable=1, RCnt=Count.
  - On RReady: RcvOut<=Receive; compare against generator; advance generator; increment index.
  - On mismatch: ErrCnt+1 (saturating); FirstErrIdx<=index if ErrCnt was 0.
  - After Count words: REnable=0, go to FIN. RReady beyond Count is ignored.
- FIN: Done=1 for one cycle, Busy=0, WCnt/RCnt<=0, go to IDLE. Status outputs hold until the next Start.
- Generator update, per accepted word:
  - increment: g+1, mod 2^DW
  - constant: g unchanged
  - LFSR: g = (g>>1) ^ (g[0] ? LFSR_TAPS : 0); seed 0 is replaced by 1 at load
  - walking-one: rotate left by 1; seed 0 is replaced by 1
- Timeout: idle counter clears on every WTake/RReady/WDone and on phase entry, and counts otherwise in W_RUN, W_WAIT and R_RUN. When it reaches TimeoutLim (nonzero): set Timeout, drop WEnable/REnable, go to FIN. TimeoutLim=0 disables the timeout.
- Start while Busy: ignored. Reset mid-operation: immediate return to reset values; no Done.

Test Plan:
- Mode0, PatSel0, Seed=16'h12FA, Count=10, WTake every cycle, WDone 2 cycles after the last take -> Send sequence 12FA..1303, WEnable high 12 cycles, one Done, ShortW=0.
- Mode2, PatSel2, Seed=16'hACE1, Count=5, loopback returns the written words -> ErrCnt=0; RcvOut equals the 5th LFSR word.
- Mode1, PatSel0, Seed=0, Count=4, Receive=0,1,7,3 -> ErrCnt=1, FirstErrIdx=2, RcvOut=3.
- Mode0, Count=8, WDone after 3 takes -> ShortW=1, WEnable low the next cycle, Done pulses.
- Mode1, Count=4, TimeoutLim=20, only 2 RReady -> Timeout=1 exactly 20 idle cycles after the 2nd word, REnable=0, Done.
- Start while Busy, and RST low mid-write -> second Start ignored; after reset all outputs 0 and no Done pulse.
